// File: rtl/proc_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access. Data wins ties unless the fetch has starved.
// Grant edge, then a one-cycle mem_en, then done in the same cycle as mem_done. Requesters hold req until done; no new grants while busy.
module proc_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state;
  logic [CW-1:0]   starve_cnt;
  logic            ua_done;
  logic            can_grant;
  logic            i_starved;
  logic            d_win;
  logic            d_unaligned;
  logic            i_win;
  logic            d_mem_done;

  // The cycle that reports an unaligned reject is also the mandatory idle gap.
  always_comb begin
    can_grant   = (state == IDLE) && !ua_done;
    i_starved   = i_req && (starve_cnt == LIMIT);
    d_win       = can_grant && d_req && !i_starved;
    d_unaligned = d_win && d_addr[0];
    i_win       = can_grant && i_req && !d_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ua_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      ua_done <= d_unaligned;
      err     <= d_unaligned || ((state == IDLE) && mem_done);
      case (state)
        IDLE: begin
          if (d_win && !d_addr[0]) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (i_win) begin
            state      <= BUSY_I;
            mem_en     <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign d_mem_done = (state == BUSY_D) && mem_done;
  assign i_done     = (state == BUSY_I) && mem_done;
  assign i_rdata    = i_done ? mem_rdata : '0;
  assign d_done     = d_mem_done || ua_done;
  assign d_rdata    = d_mem_done ? mem_rdata : '0;

endmodule
